// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue
// Brief    : Circular FIFO between fetch and decode/issue with flush support.
//            Optional same-cycle bypass when empty: define INST_QUEUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enq_valid,
    input  logic [31:0]              enq_inst,
    input  logic [31:0]              enq_pc,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output logic [31:0]              deq_inst,
    output logic [31:0]              deq_pc,
    input  logic                     deq_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [31:0]   NOP_INST = 32'h0000_0013;

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   occ;

    logic empty;
    logic full;
    logic bypass_take;
    logic do_enq;
    logic do_deq;

    assign empty     = (occ == '0);
    assign full      = (occ == FULL_CNT);
    assign enq_ready = ~full & ~flush;
    assign count     = occ;

    always_comb begin
        deq_valid   = ~empty & ~flush;
        deq_inst    = empty ? NOP_INST : inst_mem[head];
        deq_pc      = empty ? 32'h0    : pc_mem[head];
        bypass_take = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
        // Empty queue forwards the fetch slot straight to decode.
        if (empty && !flush && rst_n) begin
            deq_valid   = enq_valid;
            deq_inst    = enq_valid ? enq_inst : NOP_INST;
            deq_pc      = enq_valid ? enq_pc   : 32'h0;
            bypass_take = enq_valid & deq_ready;
        end
`endif
    end

    // A bypassed instruction is consumed directly and never occupies a slot.
    assign do_deq = deq_valid & deq_ready & ~empty;
    assign do_enq = enq_valid & enq_ready & ~bypass_take;

    always_ff @(posedge clk) begin
        if (do_enq && rst_n) begin
            inst_mem[tail] <= enq_inst;
            pc_mem[tail]   <= enq_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (do_enq) begin
                tail <= tail + PTR_ONE;
            end
            if (do_deq) begin
                head <= head + PTR_ONE;
            end
            case ({do_enq, do_deq})
                2'b10:   occ <= occ + CNT_ONE;
                2'b01:   occ <= occ - CNT_ONE;
                default: occ <= occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enq_valid  input  1  fetch stage presents an instruction.
REQ-005 SHALL have port enq_inst  input  32  fetched instruction word.
REQ-006 SHALL have port enq_pc  input  32  PC of the fetched instruction.
REQ-007 SHALL have port enq_ready  output  1  queue accepts the enqueue this cycle.
REQ-008 SHALL have port deq_valid  output  1  head instruction presented to the decode/issue stage.
REQ-009 SHALL have port deq_inst  output  32  head instruction word.
REQ-010 SHALL have port deq_pc  output  32  head instruction PC.
REQ-011 SHALL have port deq_ready  input  1  decode/issue stage issued the head (reservation station free).
REQ-012 SHALL have port flush  input  1  discard all entries (branch/jump redirect).
REQ-013 SHALL have port count  output  clog2(DEPTH)+1  valid entries held.

Function
REQ-014 SHALL buffer instructions in FIFO order: circular storage, head pointer, tail pointer, occupancy counter.
REQ-015 SHALL complete an enqueue when enq_valid & enq_ready on a rising edge: entry written at tail, tail advances.
REQ-016 SHALL complete a dequeue when deq_valid & deq_ready on a rising edge: head advances.
REQ-017 SHALL wrap head and tail from DEPTH-1 to 0.
REQ-018 SHALL drive enq_ready = (count != DEPTH) & ~flush; enq_ready SHALL NOT depend on deq_ready.
REQ-019 SHALL drive deq_valid = (count != 0) & ~flush, except as extended by REQ-027.
REQ-020 SHALL, on simultaneous enqueue and dequeue, leave count unchanged and advance both pointers.
REQ-021 SHALL, when full, refuse enqueue even if a dequeue occurs in the same cycle.
REQ-022 SHALL, when empty, drive deq_inst = 32'h00000013 (NOP) and deq_pc = 32'h0.
REQ-023 SHALL treat flush as highest priority: the next edge clears head, tail and count to 0. Any enqueue or dequeue in the flush cycle is discarded.
REQ-024 SHALL keep deq_inst/deq_pc stable while deq_valid=1 and deq_ready=0.
REQ-025 SHALL enforce default latency: an instruction enqueued at edge N is presented at earliest in the cycle after edge N.

Reset
REQ-026 SHALL, while rst_n=0, force head=0, tail=0, count=0, deq_valid=0, deq_inst=32'h00000013, deq_pc=0, enq_ready=1 (if flush=0). Assertion SHALL take effect immediately and abort any transfer in progress. Storage contents need not be cleared.

Configuration
REQ-027 SHALL, with macro INST_QUEUE_BYPASS_EN defined, when count=0 and flush=0:
- drive deq_valid = enq_valid, deq_inst = enq_inst, deq_pc = enq_pc combinationally.
- if deq_ready=1, consume the instruction without writing it; count stays 0.
- if deq_ready=0, store it normally.
REQ-028 SHALL, without INST_QUEUE_BYPASS_EN, have no enq-to-deq combinational path; REQ-025 latency applies.

Verification
REQ-029 SHALL cover reset mid-operation: 3 entries queued, rst_n low -> count=0, deq_valid=0, deq_inst=32'h00000013 immediately.
REQ-030 SHALL cover fill: DEPTH=4, deq_ready=0, enqueue 5 instructions (pc 0x0,0x4,0x8,0xC,0x10) -> count=4, enq_ready=0, pc 0x10 not accepted.
REQ-031 SHALL cover order and wrap: enqueue 6, dequeue continuously -> deq_pc sequence 0x0..0x14 in order across pointer wrap.
REQ-032 SHALL cover simultaneous transfer: count=2, enq and deq in the same cycle -> count stays 2, head pc advances by 4.
REQ-033 SHALL cover flush: count=3, flush=1 with enq_valid=1 -> deq_valid=0 that cycle, count=0 next cycle, flushed-cycle instruction absent.
REQ-034 SHALL cover bypass: with INST_QUEUE_BYPASS_EN, empty queue, enq_inst=32'h00500093, deq_ready=1 -> deq_inst=32'h00500093 same cycle, count remains 0. Without the macro: deq_valid=0 that cycle, valid next cycle.
